// File: rtl/sample_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sample_pkg
//  Purpose  : Shared FSM state and steer-code encoding for the sample
//             selector / demux pair, so both blocks decode sw/sw2 identically.
//  Revision : 1.0  initial release
// ============================================================================
package sample_pkg;

    localparam int DW_DEFAULT = 16;
    localparam int SW2_W      = 6;

    // Code 2'd3 is deliberately unused; the FSM recovers to ST_INIT from it.
    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_CLR  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [SW2_W-1:0] SW2_CH1A = 6'd0;
    localparam logic [SW2_W-1:0] SW2_CH2  = 6'd1;
    localparam logic [SW2_W-1:0] SW2_CH1B = 6'd2;

endpackage : sample_pkg
`default_nettype wire

// File: rtl/sample_steer_dec.sv
`default_nettype none
// ============================================================================
//  Module   : sample_steer_dec
//  Purpose  : Combinational decode of {sw, sw2} into a channel-1 select and a
//             burst-terminate flag. Shared with the sample selector.
//  Revision : 1.0  initial release
// ============================================================================
module sample_steer_dec
    import sample_pkg::*;
(
    input  logic             sw,
    input  logic [SW2_W-1:0] sw2,
    output logic             sel_ch1,
    output logic             term
);

    // Steered codes CH1A/CH1B go to channel 1; CH2 and every other code go to
    // channel 2. Pass-through (sw=0) always lands on channel 2.
    always_comb begin
        sel_ch1 = 1'b0;
        term    = sw;
        if (sw) begin
            if (sw2 == SW2_CH1A)
                sel_ch1 = 1'b1;
            else if (sw2 == SW2_CH2)
                sel_ch1 = 1'b0;
            else if (sw2 == SW2_CH1B)
                sel_ch1 = 1'b1;
            else
                sel_ch1 = 1'b0;
        end
    end

endmodule : sample_steer_dec
`default_nettype wire

// File: rtl/sample_demux.sv
`default_nettype none
// ============================================================================
//  Module   : sample_demux
//  Purpose  : Distributes one sample stream onto two registered output
//             channels, steered by sw/sw2, with a bounded pass-through burst
//             counter framing each burst.
//  Revision : 1.0  initial release
// ============================================================================
module sample_demux
    import sample_pkg::*;
#(
    parameter int DW       = DW_DEFAULT,
    parameter int LOOP_MAX = 100,
    parameter int CW       = 8,
    parameter int SEED     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    in,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic             sw,
    input  logic [SW2_W-1:0] sw2,
    output logic [DW-1:0]    out1,
    output logic             out1_vld,
    output logic [DW-1:0]    out2,
    output logic             out2_vld,
    output logic [DW-1:0]    tag,
    output logic             burst_done
);

    localparam logic [CW-1:0] c_loop_max = CW'(LOOP_MAX);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_i;

    logic w_sel_ch1;
    logic w_term;
    logic w_ld1;
    logic w_ld2;
    logic w_inc;
    logic w_clr;
    logic w_ld_tag;
    logic w_done;
    logic w_rdy;

    sample_steer_dec u_dec (
        .sw      (sw),
        .sw2     (sw2),
        .sel_ch1 (w_sel_ch1),
        .term    (w_term)
    );

    // State register; reset drops straight back to INIT, discarding any burst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= ST_INIT;
        else
            r_state <= w_state_nxt;
    end

    // Next-state and per-cycle control decode. burst_done and in_rdy are
    // combinational from state so the terminating cycle refuses input itself.
    always_comb begin
        w_state_nxt = r_state;
        w_ld1       = 1'b0;
        w_ld2       = 1'b0;
        w_inc       = 1'b0;
        w_clr       = 1'b0;
        w_ld_tag    = 1'b0;
        w_done      = 1'b0;
        w_rdy       = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_ld_tag    = 1'b1;
                w_state_nxt = ST_CLR;
            end
            ST_CLR: begin
                w_clr       = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (r_i >= c_loop_max) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_CLR;
                end else begin
                    w_rdy = 1'b1;
                    if (in_vld) begin
                        if (w_term) begin
                            w_ld1       = w_sel_ch1;
                            w_ld2       = ~w_sel_ch1;
                            w_state_nxt = ST_INIT;
                        end else begin
                            w_ld2 = 1'b1;
                            w_inc = 1'b1;
                        end
                    end
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Loop counter: cleared in CLR, advanced once per accepted pass-through.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_i <= '0;
        else if (w_clr)
            r_i <= '0;
        else if (w_inc)
            r_i <= r_i + CW'(1);
    end

    // Output datapath: data registers hold, strobes pulse for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out1     <= '0;
            out2     <= '0;
            tag      <= '0;
            out1_vld <= 1'b0;
            out2_vld <= 1'b0;
        end else begin
            out1_vld <= w_ld1;
            out2_vld <= w_ld2;
            if (w_ld1)
                out1 <= in;
            if (w_ld2)
                out2 <= in;
            if (w_ld_tag)
                tag <= DW'(SEED);
        end
    end

    assign in_rdy     = w_rdy;
    assign burst_done = w_done;

endmodule : sample_demux
`default_nettype wire

// File: tb/tb_sample_demux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sample_demux
//  Purpose  : Self-checking bench for sample_demux: routing table, burst
//             framing, valid gaps, async reset mid-burst, random traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sample_demux;

    localparam int LOOP_MAX = 100;
    localparam int SEED     = 10;

    logic        clk;
    logic        rst;
    logic [15:0] in_d;
    logic        in_vld;
    logic        in_rdy;
    logic        sw;
    logic [5:0]  sw2;
    logic [15:0] out1;
    logic        out1_vld;
    logic [15:0] out2;
    logic        out2_vld;
    logic [15:0] tag;
    logic        burst_done;

    sample_demux #(
        .DW       (16),
        .LOOP_MAX (LOOP_MAX),
        .CW       (8),
        .SEED     (SEED)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in_d),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .sw         (sw),
        .sw2        (sw2),
        .out1       (out1),
        .out1_vld   (out1_vld),
        .out2       (out2),
        .out2_vld   (out2_vld),
        .tag        (tag),
        .burst_done (burst_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          ch;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        logic        sw;
        logic [5:0]  sw2;
        logic [15:0] data;
        int          ch;
    } vec_t;

    exp_t sbq[$];

    int tests = 0;
    int fails = 0;

    // Reference model state.
    int          m_state;
    int          m_i;
    logic [15:0] m_out1;
    logic [15:0] m_out2;
    logic [15:0] m_tag;

    // Observations from the most recent cycle.
    bit obs_rdy;
    bit obs_done;
    bit obs_acc;
    int obs_ch;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_i     = 0;
        m_out1  = '0;
        m_out2  = '0;
        m_tag   = '0;
        sbq.delete();
    endtask

    // One clock: drive, check combinational outputs, advance model, then check
    // registered outputs against the scoreboard. Entered and left at posedge+1.
    task automatic cycle(input bit vld, input bit s, input bit [5:0] s2, input bit [15:0] d);
        bit   rdy_m;
        bit   done_m;
        exp_t e;
        in_vld = vld;
        sw     = s;
        sw2    = s2;
        in_d   = d;
        #1;
        rdy_m  = (m_state == 2) && (m_i < LOOP_MAX);
        done_m = (m_state == 2) && (m_i >= LOOP_MAX);
        chk("in_rdy", in_rdy, rdy_m);
        chk("burst_done", burst_done, done_m);
        obs_rdy  = in_rdy;
        obs_done = burst_done;
        obs_acc  = rdy_m && vld;
        case (m_state)
            0: begin
                m_state = 1;
                m_tag   = 16'(SEED);
            end
            1: begin
                m_state = 2;
                m_i     = 0;
            end
            default: begin
                if (done_m) begin
                    m_state = 1;
                end else if (obs_acc) begin
                    if (s) begin
                        m_state = 0;
                        e.ch    = (s2 == 6'd0 || s2 == 6'd2) ? 1 : 2;
                    end else begin
                        e.ch = 2;
                        m_i++;
                    end
                    e.data = d;
                    sbq.push_back(e);
                end
            end
        endcase
        @(posedge clk);
        #1;
        obs_ch = 0;
        if (sbq.size() > 0) begin
            e      = sbq.pop_front();
            obs_ch = e.ch;
            if (e.ch == 1)
                m_out1 = e.data;
            else
                m_out2 = e.data;
        end
        chk("out1_vld", out1_vld, obs_ch == 1);
        chk("out2_vld", out2_vld, obs_ch == 2);
        chk("out1", out1, m_out1);
        chk("out2", out2, m_out2);
        chk("tag", tag, m_tag);
    endtask

    // Asynchronous reset pulse placed mid-phase; leaves at posedge+1 with rst high.
    task automatic async_reset();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_out1", out1, 0);
        chk("rst_out2", out2, 0);
        chk("rst_tag", tag, 0);
        chk("rst_strobes", {out1_vld, out2_vld, burst_done, in_rdy}, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (!((m_state == 2) && (m_i < LOOP_MAX)) && n < 10) begin
            cycle(1'b0, 1'b0, 6'd0, 16'h0);
            n++;
        end
        chk("wait_rdy_timeout", n < 10, 1);
    endtask

    // Feed pass-through samples (optionally gapped) until burst_done; returns
    // the number of accepted samples before burst_done appeared.
    task automatic run_burst(input bit gaps, input bit [15:0] base, output int acc, output bit seen);
        int k = 0;
        acc  = 0;
        seen = 0;
        while (!seen && k < 500) begin
            cycle(gaps ? k[0] == 1'b0 : 1'b1, 1'b0, 6'd0, base + 16'(acc));
            if (obs_done) seen = 1;
            else if (obs_acc) acc++;
            if (gaps && !obs_acc && !obs_done)
                chk("gap_no_strobe", {out1_vld, out2_vld}, obs_ch == 2 ? 2'b01 : 2'b00);
            k++;
        end
        chk("burst_timeout", seen, 1);
    endtask

    vec_t vecs[6];
    int   acc;
    bit   seen;

    initial begin
        vecs[0] = '{sw: 1'b1, sw2: 6'd0,  data: 16'h1234, ch: 1};
        vecs[1] = '{sw: 1'b1, sw2: 6'd1,  data: 16'h1234, ch: 2};
        vecs[2] = '{sw: 1'b1, sw2: 6'd2,  data: 16'h1234, ch: 1};
        vecs[3] = '{sw: 1'b1, sw2: 6'd5,  data: 16'h1234, ch: 2};
        vecs[4] = '{sw: 1'b1, sw2: 6'd63, data: 16'hBEEF, ch: 2};
        vecs[5] = '{sw: 1'b1, sw2: 6'd3,  data: 16'h0F0F, ch: 2};

        rst    = 1'b0;
        in_d   = '0;
        in_vld = 1'b0;
        sw     = 1'b0;
        sw2    = '0;
        model_reset();
        #1;
        chk("por_outputs", {out1, out2, tag}, 0);
        chk("por_strobes", {out1_vld, out2_vld, burst_done, in_rdy}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset sequencing: INIT, CLR not ready; RUN ready with tag loaded.
        cycle(1'b0, 1'b0, 6'd0, 16'h0);
        chk("seq_init_rdy", obs_rdy, 0);
        cycle(1'b0, 1'b0, 6'd0, 16'h0);
        chk("seq_clr_rdy", obs_rdy, 0);
        chk("seq_tag", tag, 16'd10);
        cycle(1'b0, 1'b0, 6'd0, 16'h0);
        chk("seq_run_rdy", obs_rdy, 1);

        // Steered routing table.
        for (int v = 0; v < 6; v++) begin
            wait_rdy();
            cycle(1'b1, vecs[v].sw, vecs[v].sw2, vecs[v].data);
            chk("route_ch", out1_vld ? 1 : (out2_vld ? 2 : 0), vecs[v].ch);
            chk("route_data", vecs[v].ch == 1 ? out1 : out2, vecs[v].data);
            cycle(1'b1, 1'b0, 6'd0, 16'hDEAD);
            chk("route_gap1_rdy", obs_rdy, 0);
            cycle(1'b1, 1'b0, 6'd0, 16'hDEAD);
            chk("route_gap2_rdy", obs_rdy, 0);
        end

        // Back-to-back pass-through burst, data 0..99.
        wait_rdy();
        run_burst(1'b0, 16'd0, acc, seen);
        chk("burst_len", acc, LOOP_MAX);
        chk("burst_done_rdy", obs_rdy, 0);
        cycle(1'b0, 1'b0, 6'd0, 16'h0);
        chk("burst_clr_rdy", obs_rdy, 0);
        cycle(1'b0, 1'b0, 6'd0, 16'h0);
        chk("burst_resume_rdy", obs_rdy, 1);

        // Gapped burst: only accepted samples advance the counter.
        wait_rdy();
        run_burst(1'b1, 16'h4000, acc, seen);
        chk("gap_burst_len", acc, LOOP_MAX);

        // Reset after 50 transfers, then a full fresh burst.
        wait_rdy();
        acc = 0;
        for (int k = 0; k < 50; k++) begin
            cycle(1'b1, 1'b0, 6'd0, 16'h8000 + 16'(k));
            if (obs_acc) acc++;
        end
        chk("mid_pre_count", acc, 50);
        async_reset();
        wait_rdy();
        run_burst(1'b0, 16'h9000, acc, seen);
        chk("mid_post_burst_len", acc, LOOP_MAX);

        // Random traffic against the model.
        for (int k = 0; k < 10000; k++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  6'($urandom_range(0, 63)), 16'($urandom));
            chk("excl", out1_vld && out2_vld, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_sample_demux
`default_nettype wire
